// File: rtl/e_pkg.sv
// Shared types and constants for the e digit emitter: word width, ASCII codes
// and the emitter state encoding.
package e_pkg;

   localparam int         WORD_W     = 16;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_DOT  = 8'h2E;

   typedef enum logic [2:0] {
      IDLE,
      EMIT_INT,
      EMIT_DOT,
      MUL,
      EMIT_FRAC,
      DONE
   } emit_state_t;

endpackage

// File: rtl/e_mul10_word.sv
// One word of a word-serial multiply-by-10: {carry_out, word_out} = word*10 + carry_in.
module e_mul10_word
   import e_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [3:0]        carry_in,
   output logic [WORD_W-1:0] word_out,
   output logic [3:0]        carry_out
);

   logic [19:0] p;

   // 65535*10 + 9 fits in 20 bits, so the upper nibble never exceeds 9.
   always_comb begin
      p = ({4'd0, word} * 20'd10) + {16'd0, carry_in};
   end

   assign word_out  = p[15:0];
   assign carry_out = p[19:16];

endmodule

// File: rtl/e_digit_emitter.sv
// Converts a multi-word fixed-point value to an ASCII stream "I.ffff...":
// each fraction digit is the carry out of a word-serial multiply-by-10.
module e_digit_emitter
   import e_pkg::*;
#(
   parameter int WORDS      = 32,
   parameter int FRAC_WORDS = 16,
   parameter int NUM_DIGITS = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [WORDS-1:0][WORD_W-1:0] in_data,
   output logic                         busy,
   output logic                         done,
   output logic                         int_ovf,
   output logic [7:0]                   out_char,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int WI_W = (FRAC_WORDS > 1) ? $clog2(FRAC_WORDS) : 1;
   localparam int DC_W = $clog2(NUM_DIGITS + 1);
   localparam logic [WI_W-1:0] WI_LAST = WI_W'(FRAC_WORDS - 1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(NUM_DIGITS - 1);

   // Output handshake: a character transfers on a rising edge where
   // out_valid && out_ready; out_valid/out_char are registered and hold
   // until that transfer happens.

   emit_state_t                         state, state_n;
   logic [FRAC_WORDS-1:0][WORD_W-1:0]   work, work_n;
   logic [3:0]                          carry, carry_n;
   logic [WI_W-1:0]                     wi, wi_n;
   logic [DC_W-1:0]                     dcnt, dcnt_n;
   logic                                int_ovf_n;
   logic [7:0]                          out_char_n;
   logic                                out_valid_n;

   logic [WORD_W-1:0] int_word;
   logic [3:0]        int_digit;
   logic [WORD_W-1:0] mul_word;
   logic [WORD_W-1:0] mul_word_out;
   logic [3:0]        mul_carry_out;
   logic              hs;

   assign int_word  = in_data[FRAC_WORDS];
   assign int_digit = (int_word > 16'd9) ? 4'd9 : int_word[3:0];
   assign hs        = out_valid && out_ready;
   assign mul_word  = work[wi];

   e_mul10_word u_mul10 (
      .word      (mul_word),
      .carry_in  (carry),
      .word_out  (mul_word_out),
      .carry_out (mul_carry_out)
   );

   always_comb begin
      state_n     = state;
      work_n      = work;
      carry_n     = carry;
      wi_n        = wi;
      dcnt_n      = dcnt;
      int_ovf_n   = int_ovf;
      out_char_n  = out_char;
      out_valid_n = out_valid;
      case (state)
         IDLE: begin
            if (start) begin
               work_n      = in_data[FRAC_WORDS-1:0];
               int_ovf_n   = (int_word > 16'd9);
               out_char_n  = ASCII_ZERO + {4'd0, int_digit};
               out_valid_n = 1'b1;
               carry_n     = 4'd0;
               wi_n        = '0;
               dcnt_n      = '0;
               state_n     = EMIT_INT;
            end
         end
         EMIT_INT: begin
            if (hs) begin
               out_char_n = ASCII_DOT;
               state_n    = EMIT_DOT;
            end
         end
         EMIT_DOT: begin
            if (hs) begin
               out_valid_n = 1'b0;
               carry_n     = 4'd0;
               wi_n        = '0;
               state_n     = MUL;
            end
         end
         MUL: begin
            work_n[wi] = mul_word_out;
            carry_n    = mul_carry_out;
            // The carry out of the most significant fraction word is the next digit.
            if (wi == WI_LAST) begin
               out_valid_n = 1'b1;
               out_char_n  = ASCII_ZERO + {4'd0, mul_carry_out};
               state_n     = EMIT_FRAC;
            end else begin
               wi_n = wi + 1'b1;
            end
         end
         EMIT_FRAC: begin
            if (hs) begin
               out_valid_n = 1'b0;
               dcnt_n      = dcnt + 1'b1;
               if (dcnt == DC_LAST) begin
                  state_n = DONE;
               end else begin
                  carry_n = 4'd0;
                  wi_n    = '0;
                  state_n = MUL;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= '0;
         carry     <= 4'd0;
         wi        <= '0;
         dcnt      <= '0;
         int_ovf   <= 1'b0;
         out_char  <= 8'h00;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         work      <= work_n;
         carry     <= carry_n;
         wi        <= wi_n;
         dcnt      <= dcnt_n;
         int_ovf   <= int_ovf_n;
         out_char  <= out_char_n;
         out_valid <= out_valid_n;
      end
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

endmodule
